sweep_sequencer: RTL and testbench
==================================

SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

Interface
REQ-001 Parameter DW, default 32: width of delay values and timeout counter.
REQ-002 Parameter TW, default 16: width of the tries-per-delay count.
REQ-003 clk  in  1  sole clock; all logic on posedge clk.
REQ-004 rst  in  1  synchronous, active-low reset; rst==0 at a posedge resets the block.
REQ-005 start  in  1  single-cycle request to begin a sweep; sampled only in IDLE.
REQ-006 abort  in  1  terminates the sweep from any state.
REQ-007 cfg_delay_start, cfg_delay_end, cfg_delay_step  in  DW each  sweep bounds and increment; latched at start.
REQ-008 cfg_tries  in  TW  attempts per delay value; latched at start.
REQ-009 cfg_timeout  in  DW  cycles to wait for success after glitch_done; latched at start.
REQ-010 trigger  in  1  pulse from the trigger detector.
REQ-011 glitch_done  in  1  pulse from the delay module when the glitch has fired.
REQ-012 success  in  1  pulse from the success detector.
REQ-013 delay  out  DW  current delay value to the delay module.
REQ-014 set_delay  out  1  one-cycle load strobe for delay.
REQ-015 trigger_arm  out  1  arms the trigger detector (level).
REQ-016 success_arm  out  1  arms the success detector (level).
REQ-017 result_valid, result_delay[DW], result_success  out  attempt-result record; result_ready  in  1  consumer acceptance.
REQ-018 busy  out  1  high outside IDLE; done  out  1  one-cycle pulse on normal sweep completion.

Function
REQ-019 States: IDLE, LOAD, ARM_TRIG, WAIT_GLITCH, WAIT_SUCC, REPORT, NEXT.
REQ-020 IDLE: start=1 latches all cfg_* inputs, sets cur_delay=cfg_delay_start, try_cnt=0, -> LOAD.
REQ-021 LOAD: delay=cur_delay, set_delay=1 for exactly this cycle, -> ARM_TRIG.
REQ-022 ARM_TRIG: trigger_arm=1; trigger=1 -> WAIT_GLITCH with trigger_arm deasserted from the next cycle; success ignored.
REQ-023 WAIT_GLITCH: glitch_done=1 -> WAIT_SUCC, timeout counter cleared to 0.
REQ-024 WAIT_SUCC: success_arm=1; counter increments each cycle; success=1 -> REPORT with result_success=1; counter==timeout-1 without success -> REPORT with result_success=0.
REQ-025 success on the same cycle as timeout expiry SHALL be recorded as success.
REQ-026 cfg_timeout==0 SHALL behave as 1 (one-cycle window).
REQ-027 REPORT: result_valid=1, result_delay=cur_delay, result_success held stable until result_ready=1; transfer on valid&ready, -> NEXT.
REQ-028 NEXT: try_cnt+1 < tries -> try_cnt++, -> ARM_TRIG (no reload); else try_cnt=0 and advance delay.
REQ-029 Delay advance: next = cur_delay + step computed DW+1 bits wide; carry-out or next > end -> done=1, -> IDLE; else cur_delay=next, -> LOAD.
REQ-030 cfg_delay_step==0 SHALL be treated as 1; cfg_tries==0 SHALL be treated as 1.
REQ-031 cfg_delay_end < cfg_delay_start: exactly one delay (start) is swept.
REQ-032 abort=1 in any non-IDLE state: next cycle IDLE, trigger_arm=success_arm=result_valid=0, done not pulsed; abort has priority over all other inputs.
REQ-033 start while busy SHALL be ignored; cfg_* changes mid-sweep have no effect.
REQ-034 trigger_arm and success_arm SHALL never be high in the same cycle.

Reset
REQ-035 rst==0: state=IDLE; delay=0, set_delay=0, trigger_arm=0, success_arm=0, result_valid=0, result_delay=0, result_success=0, busy=0, done=0; internal counters 0.
REQ-036 Reset asserted mid-sweep SHALL abandon the sweep identically to REQ-035, regardless of pending handshakes.

Verification
REQ-037 start=5, end=7, step=1, tries=1, success every attempt, ready tied 1 -> three results delay 5,6,7 success=1, three set_delay pulses, one done pulse.
REQ-038 timeout=4, no success after glitch_done -> success_arm high exactly 4 cycles, result_success=0.
REQ-039 start=0xFFFFFFF0, end=0xFFFFFFFF, step=0x10 -> one attempt at 0xFFFFFFF0, carry terminates sweep, done pulses.
REQ-040 tries=3, result_ready held 0 for 10 cycles in REPORT -> result_valid and fields stable 10 cycles; 3 results at same delay, one set_delay.
REQ-041 abort during WAIT_SUCC -> next cycle IDLE, success_arm=0, busy=0, no done pulse; new start restarts from cfg_delay_start.
REQ-042 rst=0 during ARM_TRIG -> all outputs at REQ-035 values after that edge; success on timeout-expiry cycle -> result_success=1.

Source files
------------

// File: rtl/sweep_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sweep_sequencer
// Purpose  : Steps a glitch delay from a start value to an end value. For each
//            delay value it loads the delay module, then runs a number of
//            attempts. Each attempt arms the trigger detector, waits for the
//            glitch, waits a bounded window for success, and reports the result.
// Ports    : clk, rst (sync, active-low)
//            start, abort                        - sweep control
//            cfg_delay_start/end/step, cfg_tries,
//            cfg_timeout                         - sweep configuration, latched at start
//            trigger, glitch_done, success       - event pulses from the detectors
//            delay, set_delay                    - delay value and its load strobe
//            trigger_arm, success_arm            - detector arm levels
//            result_valid/ready, result_delay,
//            result_success                      - per-attempt result record
//            busy, done                          - status
// Revision : 1.0 - initial release
// ============================================================================
module sweep_sequencer #(
    parameter int DW = 32,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] cfg_delay_start,
    input  logic [DW-1:0] cfg_delay_end,
    input  logic [DW-1:0] cfg_delay_step,
    input  logic [TW-1:0] cfg_tries,
    input  logic [DW-1:0] cfg_timeout,
    input  logic          trigger,
    input  logic          glitch_done,
    input  logic          success,
    output logic [DW-1:0] delay,
    output logic          set_delay,
    output logic          trigger_arm,
    output logic          success_arm,
    output logic          result_valid,
    output logic [DW-1:0] result_delay,
    output logic          result_success,
    input  logic          result_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] c_IDLE        = 3'd0;
    localparam logic [2:0] c_LOAD        = 3'd1;
    localparam logic [2:0] c_ARM_TRIG    = 3'd2;
    localparam logic [2:0] c_WAIT_GLITCH = 3'd3;
    localparam logic [2:0] c_WAIT_SUCC   = 3'd4;
    localparam logic [2:0] c_REPORT      = 3'd5;
    localparam logic [2:0] c_NEXT        = 3'd6;

    localparam logic [DW-1:0] c_ONE_DW = DW'(1);
    localparam logic [TW-1:0] c_ONE_TW = TW'(1);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;

    // Configuration latched at start; zero step/tries/timeout are stored as 1
    // so the datapath never has to special-case them later.
    logic [DW-1:0] r_end;
    logic [DW-1:0] r_step;
    logic [DW-1:0] r_timeout;
    logic [TW-1:0] r_tries;

    logic [DW-1:0] r_cur_delay;
    logic [TW-1:0] r_try_cnt;
    logic [DW-1:0] r_tcnt;
    logic          r_result_success;
    logic          r_done;

    logic [DW:0]   w_next_delay;
    logic [TW:0]   w_try_inc;
    logic          w_more_tries;
    logic          w_sweep_over;
    logic          w_timeout_hit;

    // Both sums are one bit wider so a wrap past the top of the range is seen
    // as a carry rather than silently restarting at a small value.
    assign w_next_delay  = {1'b0, r_cur_delay} + {1'b0, r_step};
    assign w_sweep_over  = w_next_delay[DW] | (w_next_delay[DW-1:0] > r_end);
    assign w_try_inc     = {1'b0, r_try_cnt} + {1'b0, c_ONE_TW};
    assign w_more_tries  = w_try_inc < {1'b0, r_tries};
    assign w_timeout_hit = (r_tcnt == (r_timeout - c_ONE_DW));

    // ------------------------------------------------------------------ state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:        if (start)       w_state_nxt = c_LOAD;
                c_LOAD:                         w_state_nxt = c_ARM_TRIG;
                c_ARM_TRIG:    if (trigger)     w_state_nxt = c_WAIT_GLITCH;
                c_WAIT_GLITCH: if (glitch_done) w_state_nxt = c_WAIT_SUCC;
                c_WAIT_SUCC:   if (success || w_timeout_hit) w_state_nxt = c_REPORT;
                c_REPORT:      if (result_ready) w_state_nxt = c_NEXT;
                c_NEXT: begin
                    if (w_more_tries)      w_state_nxt = c_ARM_TRIG;
                    else if (w_sweep_over) w_state_nxt = c_IDLE;
                    else                   w_state_nxt = c_LOAD;
                end
                default:                        w_state_nxt = c_IDLE;
            endcase
        end
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_end            <= '0;
            r_step           <= '0;
            r_timeout        <= '0;
            r_tries          <= '0;
            r_cur_delay      <= '0;
            r_try_cnt        <= '0;
            r_tcnt           <= '0;
            r_result_success <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start && !abort) begin
                        r_end       <= cfg_delay_end;
                        r_step      <= (cfg_delay_step == '0) ? c_ONE_DW : cfg_delay_step;
                        r_timeout   <= (cfg_timeout == '0) ? c_ONE_DW : cfg_timeout;
                        r_tries     <= (cfg_tries == '0) ? c_ONE_TW : cfg_tries;
                        r_cur_delay <= cfg_delay_start;
                        r_try_cnt   <= '0;
                    end
                end
                c_WAIT_GLITCH: begin
                    if (glitch_done) r_tcnt <= '0;
                end
                c_WAIT_SUCC: begin
                    r_tcnt <= r_tcnt + c_ONE_DW;
                    // success wins when it coincides with the last window cycle
                    if (success || w_timeout_hit) r_result_success <= success;
                end
                c_NEXT: begin
                    if (!abort) begin
                        if (w_more_tries) begin
                            r_try_cnt <= w_try_inc[TW-1:0];
                        end else begin
                            r_try_cnt <= '0;
                            if (w_sweep_over) r_done      <= 1'b1;
                            else              r_cur_delay <= w_next_delay[DW-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        set_delay    = 1'b0;
        trigger_arm  = 1'b0;
        success_arm  = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            c_LOAD:      set_delay    = 1'b1;
            c_ARM_TRIG:  trigger_arm  = 1'b1;
            c_WAIT_SUCC: success_arm  = 1'b1;
            c_REPORT:    result_valid = 1'b1;
            default: ;
        endcase
    end

    assign busy           = (r_state != c_IDLE);
    assign done           = r_done;
    assign delay          = r_cur_delay;
    assign result_delay   = r_cur_delay;
    assign result_success = r_result_success;

endmodule
`default_nettype wire

// File: tb/tb_sweep_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sweep_sequencer
// Purpose  : Directed self-checking bench for sweep_sequencer. The bench plays
//            the trigger detector, delay module, success detector and result
//            consumer by hand, and compares DUT outputs against hand-computed
//            values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sweep_sequencer;

    localparam int DW = 32;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] cfg_delay_start = '0;
    logic [DW-1:0] cfg_delay_end = '0;
    logic [DW-1:0] cfg_delay_step = '0;
    logic [TW-1:0] cfg_tries = '0;
    logic [DW-1:0] cfg_timeout = '0;
    logic          trigger = 1'b0;
    logic          glitch_done = 1'b0;
    logic          success = 1'b0;
    logic          result_ready = 1'b1;
    logic [DW-1:0] delay;
    logic          set_delay;
    logic          trigger_arm;
    logic          success_arm;
    logic          result_valid;
    logic [DW-1:0] result_delay;
    logic          result_success;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    sweep_sequencer #(.DW(DW), .TW(TW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .cfg_delay_start (cfg_delay_start),
        .cfg_delay_end   (cfg_delay_end),
        .cfg_delay_step  (cfg_delay_step),
        .cfg_tries       (cfg_tries),
        .cfg_timeout     (cfg_timeout),
        .trigger         (trigger),
        .glitch_done     (glitch_done),
        .success         (success),
        .delay           (delay),
        .set_delay       (set_delay),
        .trigger_arm     (trigger_arm),
        .success_arm     (success_arm),
        .result_valid    (result_valid),
        .result_delay    (result_delay),
        .result_success  (result_success),
        .result_ready    (result_ready),
        .busy            (busy),
        .done            (done)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Event counters sampled mid-cycle, away from the active edge
    int n_set = 0, n_done = 0, n_sarm = 0, n_res = 0, n_succ = 0, n_overlap = 0;
    logic [DW-1:0] res_d[$];

    always @(negedge clk) begin
        if (set_delay)   n_set++;
        if (done)        n_done++;
        if (success_arm) n_sarm++;
        if (trigger_arm && success_arm) n_overlap++;
        if (result_valid && result_ready) begin
            n_res++;
            if (result_success) n_succ++;
            res_d.push_back(result_delay);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return trigger_arm;
            1:       return result_valid;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input string tag);
        int k;
        k = 0;
        while (k < 60 && sig(sel) !== 1'b1) begin
            step();
            k++;
        end
        check(tag, {63'd0, sig(sel)}, 64'd1);
    endtask

    function automatic logic [DW-1:0] qd(input int i);
        if (i < res_d.size()) return res_d[i];
        return 'x;
    endfunction

    task automatic clr();
        n_set = 0; n_done = 0; n_sarm = 0; n_res = 0; n_succ = 0;
        res_d.delete();
    endtask

    task automatic configure(input logic [DW-1:0] s, input logic [DW-1:0] e,
                             input logic [DW-1:0] st, input logic [TW-1:0] tr,
                             input logic [DW-1:0] to);
        cfg_delay_start = s;
        cfg_delay_end   = e;
        cfg_delay_step  = st;
        cfg_tries       = tr;
        cfg_timeout     = to;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Plays one attempt: trigger, glitch, and optionally an immediate success.
    // Returns in REPORT when succ=1, or in the first WAIT_SUCC cycle when succ=0.
    task automatic attempt(input bit succ);
        wait_sig(0, "arm_wait");
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        glitch_done = 1'b1;
        step();
        glitch_done = 1'b0;
        if (succ) begin
            success = 1'b1;
            step();
            success = 1'b0;
        end
    endtask

    initial begin
        int stable;

        // ---- reset state
        rst = 1'b0;
        step();
        step();
        check("rst_vals", {result_delay, delay}, 64'd0);
        check("rst_flags", {set_delay, trigger_arm, success_arm, result_valid,
                            result_success, busy, done}, 64'd0);
        rst = 1'b1;
        step();

        // ---- basic sweep 5..7, one try each, all successful
        configure(5, 7, 1, 1, 8);
        clr();
        go();
        check("load_delay", delay, 5);
        check("load_strobe", set_delay, 1);
        repeat (3) attempt(1);
        wait_sig(2, "idle_basic");
        step();
        check("basic_nres", n_res, 3);
        check("basic_d0", qd(0), 5);
        check("basic_d1", qd(1), 6);
        check("basic_d2", qd(2), 7);
        check("basic_nsucc", n_succ, 3);
        check("basic_nset", n_set, 3);
        check("basic_ndone", n_done, 1);

        // ---- timeout 4, no success
        configure(10, 10, 1, 1, 4);
        clr();
        go();
        attempt(0);
        wait_sig(1, "rv_timeout");
        check("to_result_success", result_success, 0);
        check("to_result_delay", result_delay, 10);
        check("to_sarm_cycles", n_sarm, 4);
        wait_sig(2, "idle_timeout");
        step();
        check("to_ndone", n_done, 1);

        // ---- carry out of the top of the range terminates the sweep
        configure(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 1, 4);
        clr();
        go();
        attempt(1);
        wait_sig(2, "idle_carry");
        step();
        check("carry_nres", n_res, 1);
        check("carry_d0", qd(0), 32'hFFFF_FFF0);
        check("carry_nset", n_set, 1);
        check("carry_ndone", n_done, 1);

        // ---- three tries, consumer stalls 10 cycles each time
        configure(32'h20, 32'h20, 1, 3, 4);
        result_ready = 1'b0;
        clr();
        go();
        for (int a = 0; a < 3; a++) begin
            attempt(1);
            stable = 0;
            for (int c = 0; c < 10; c++) begin
                if (result_valid === 1'b1 && result_delay === 32'h20 && result_success === 1'b1)
                    stable++;
                if (c < 9) step();
            end
            check("stall_stable", stable, 10);
            result_ready = 1'b1;
            step();
            result_ready = 1'b0;
        end
        result_ready = 1'b1;
        wait_sig(2, "idle_tries");
        step();
        check("tries_nres", n_res, 3);
        check("tries_d0", qd(0), 32'h20);
        check("tries_d2", qd(2), 32'h20);
        check("tries_nset", n_set, 1);
        check("tries_ndone", n_done, 1);

        // ---- abort in WAIT_SUCC, then restart; start/cfg ignored while busy
        configure(3, 9, 2, 1, 20);
        go();
        attempt(0);
        step();
        step();
        check("pre_abort_sarm", success_arm, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_flags", {busy, success_arm, trigger_arm, result_valid}, 64'd0);
        clr();
        step();
        check("abort_ndone", n_done, 0);
        go();
        check("restart_delay", delay, 3);
        check("restart_strobe", set_delay, 1);
        cfg_delay_start = 100;
        cfg_delay_step  = 7;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_start_ignored", delay, 3);
        attempt(1);
        check("busy_result_delay", result_delay, 3);
        wait_sig(0, "arm_second");
        check("latched_step", delay, 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort2_busy", busy, 0);
        step();
        check("abort2_ndone", n_done, 0);
        check("abort2_nset", n_set, 2);

        // ---- reset during ARM_TRIG
        configure(32'h40, 32'h40, 1, 1, 3);
        go();
        step();
        check("arm_before_rst", trigger_arm, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("midrst_vals", {result_delay, delay}, 64'd0);
        check("midrst_flags", {set_delay, trigger_arm, success_arm, result_valid,
                               result_success, busy, done}, 64'd0);

        // ---- success on the expiry cycle of a 3-cycle window
        clr();
        go();
        attempt(0);
        step();
        step();
        success = 1'b1;
        step();
        success = 1'b0;
        check("expiry_valid", result_valid, 1);
        check("expiry_success", result_success, 1);
        wait_sig(2, "idle_expiry");
        step();

        // ---- timeout 0 behaves as a one-cycle window
        configure(32'h41, 32'h41, 1, 1, 0);
        clr();
        go();
        attempt(0);
        wait_sig(1, "rv_to0");
        check("to0_sarm_cycles", n_sarm, 1);
        check("to0_success", result_success, 0);
        wait_sig(2, "idle_to0");
        step();

        // ---- step 0 and tries 0 both act as 1
        configure(1, 2, 0, 0, 4);
        clr();
        go();
        attempt(1);
        attempt(1);
        wait_sig(2, "idle_zero");
        step();
        check("zero_nres", n_res, 2);
        check("zero_d1", qd(1), 2);
        check("zero_ndone", n_done, 1);

        // ---- end below start: exactly one delay
        configure(9, 4, 1, 1, 4);
        clr();
        go();
        attempt(1);
        wait_sig(2, "idle_rev");
        step();
        check("rev_nres", n_res, 1);
        check("rev_d0", qd(0), 9);
        check("rev_ndone", n_done, 1);

        check("arm_overlap", n_overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
